// File: rtl/simon_pkg.sv
// Shared definitions for the Simon front end: step FSM states and default timing parameters.
package simon_pkg;

  // Default number of consecutive stable cycles before a synchronized input is accepted.
  localparam int unsigned DefaultDebounceCycles = 16;

  // Default number of cycles step_pulse stays high per accepted press.
  localparam int unsigned DefaultStepWidth = 2;

  // Number of raw inputs conditioned: button, level switch, four pattern switches.
  localparam int unsigned NumRawBits = 6;

  // Step FSM states.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFire = 2'd1,
    StHeld = 2'd2
  } step_state_e;

endpackage

// File: rtl/simon_debounce_bit.sv
// Two-flop synchronizer followed by a debounce counter for one raw asynchronous input.
// The debounced value flips on the edge that completes DEBOUNCE_CYCLES consecutive cycles
// of disagreement with the synchronized value; any agreeing cycle clears the counter.
module simon_debounce_bit
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter logic        RstVal          = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic db_o
);

  localparam int unsigned    CntW    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            db_q, db_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Count disagreement cycles; flip and clear on the last one, so the counter never wraps.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CntLast) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounced value and counter registers. The synchronizer resets to the same
  // value as the debounced output so the first post-reset cycles never look like a change.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= RstVal;
      sync2_q <= RstVal;
      db_q    <= RstVal;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
    end
  end

  assign db_o = db_q;

endmodule

// File: rtl/simon_input_conditioner.sv
// Input conditioner upstream of Simon: debounces the step button and switches, turns each
// accepted press into one STEP_WIDTH-cycle strobe, and freezes the switch outputs while the
// button is active so they are stable across every step_pulse rising edge.
module simon_input_conditioner
  import simon_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefaultDebounceCycles,
  parameter int unsigned STEP_WIDTH      = DefaultStepWidth
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_step,
  input  logic       sw_level,
  input  logic [3:0] sw_pattern,
  output logic       step_pulse,
  output logic       level_out,
  output logic [3:0] pattern_out
);

  localparam int unsigned     StepCntW = $clog2(STEP_WIDTH + 1);
  localparam logic [StepCntW-1:0] StepLast = StepCntW'(STEP_WIDTH - 1);

  logic       btn_db;
  logic       lvl_db;
  logic [3:0] pat_db;

  // Button resets to "pressed" so a button held through reset cannot fire a pulse.
  simon_debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RstVal         (1'b1)
  ) u_db_btn (
    .clk  (clk),
    .rst  (rst),
    .raw_i(btn_step),
    .db_o (btn_db)
  );

  simon_debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .RstVal         (1'b0)
  ) u_db_lvl (
    .clk  (clk),
    .rst  (rst),
    .raw_i(sw_level),
    .db_o (lvl_db)
  );

  for (genvar i = 0; i < 4; i++) begin : g_db_pat
    simon_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RstVal         (1'b0)
    ) u_db_pat (
      .clk  (clk),
      .rst  (rst),
      .raw_i(sw_pattern[i]),
      .db_o (pat_db[i])
    );
  end

  step_state_e          state_q, state_d;
  logic [StepCntW-1:0]  fire_cnt_q, fire_cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 level_q, level_d;
  logic [3:0]           pattern_q, pattern_d;

  // Step FSM next state: one pulse per debounced press, re-armed only by a debounced release.
  always_comb begin
    state_d    = state_q;
    fire_cnt_d = '0;
    case (state_q)
      StIdle: begin
        if (btn_db) begin
          state_d = StFire;
        end
      end
      StFire: begin
        // Release is ignored here so the pulse always runs its full width.
        if (fire_cnt_q == StepLast) begin
          state_d = StHeld;
        end else begin
          fire_cnt_d = fire_cnt_q + 1'b1;
        end
      end
      StHeld: begin
        if (!btn_db) begin
          state_d = StIdle;
        end
      end
      default: state_d = StHeld;
    endcase
  end

  // Registered outputs: pulse decoded from the next state so it is glitch-free for use as a
  // clock; switch values track the debounced inputs only while idle.
  always_comb begin
    pulse_d   = (state_d == StFire);
    level_d   = level_q;
    pattern_d = pattern_q;
    if (state_q == StIdle) begin
      level_d   = lvl_db;
      pattern_d = pat_db;
    end
  end

  // FSM and output registers; reset parks in HELD so a fresh press needs a release first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHeld;
      fire_cnt_q <= '0;
      pulse_q    <= 1'b0;
      level_q    <= 1'b0;
      pattern_q  <= 4'b0000;
    end else begin
      state_q    <= state_d;
      fire_cnt_q <= fire_cnt_d;
      pulse_q    <= pulse_d;
      level_q    <= level_d;
      pattern_q  <= pattern_d;
    end
  end

  assign step_pulse  = pulse_q;
  assign level_out   = level_q;
  assign pattern_out = pattern_q;

endmodule

// File: tb/tb_simon_input_conditioner.sv
// Bench for simon_input_conditioner with DEBOUNCE_CYCLES=4, STEP_WIDTH=2: a directed table of
// timed input runs with expected outputs, then randomized stimulus against a reference model.
module tb_simon_input_conditioner;

  localparam int unsigned D = 4;
  localparam int unsigned W = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_step = 1'b0;
  logic       sw_level = 1'b0;
  logic [3:0] sw_pattern = 4'b0000;
  logic       step_pulse;
  logic       level_out;
  logic [3:0] pattern_out;

  int n_tests = 0;
  int n_fail  = 0;

  simon_input_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .STEP_WIDTH     (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_step   (btn_step),
    .sw_level   (sw_level),
    .sw_pattern (sw_pattern),
    .step_pulse (step_pulse),
    .level_out  (level_out),
    .pattern_out(pattern_out)
  );

  always #5 clk = ~clk;

  // Reference model: raw bits delayed two edges, each bit's run length of disagreement,
  // and a step mode (0 idle, 1 firing, 2 held) with a count of pulse cycles issued.
  bit [5:0] dly [2];
  int       run [6];
  bit [5:0] m_db;
  int       m_mode;
  int       m_fired;
  bit       m_lvl;
  bit [3:0] m_pat;

  function automatic void model_step(bit r, bit [5:0] raw);
    bit [5:0] old_db;
    if (r) begin
      dly[0]  = 6'b100000;
      dly[1]  = 6'b100000;
      for (int i = 0; i < 6; i++) run[i] = 0;
      m_db    = 6'b100000;
      m_mode  = 2;
      m_fired = 0;
      m_lvl   = 1'b0;
      m_pat   = 4'b0000;
      return;
    end
    old_db = m_db;
    for (int i = 0; i < 6; i++) begin
      if (dly[1][i] != m_db[i]) begin
        run[i]++;
        if (run[i] == int'(D)) begin
          m_db[i] = ~m_db[i];
          run[i]  = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    if (m_mode == 0) begin
      m_lvl = old_db[4];
      m_pat = old_db[3:0];
      if (old_db[5]) begin
        m_mode  = 1;
        m_fired = 0;
      end
    end else if (m_mode == 1) begin
      m_fired++;
      if (m_fired == int'(W)) m_mode = 2;
    end else if (!old_db[5]) begin
      m_mode = 0;
    end
    dly[1] = dly[0];
    dly[0] = raw;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, {btn_step, sw_level, sw_pattern});
    #1;
  endtask

  typedef struct {
    int       n;
    bit       rst;
    bit       btn;
    bit       lvl;
    bit [3:0] pat;
    bit       e_pulse;
    bit       e_lvl;
    bit [3:0] e_pat;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int n, bit r, bit b, bit l, bit [3:0] p,
                              bit ep, bit el, bit [3:0] epat);
    vec_t v;
    v.n = n; v.rst = r; v.btn = b; v.lvl = l; v.pat = p;
    v.e_pulse = ep; v.e_lvl = el; v.e_pat = epat;
    tbl.push_back(v);
  endfunction

  initial begin
    int seg;
    // Reset, then 10 released cycles with pattern 0001: outputs load at the 8th edge.
    add(2,  1, 0, 0, 4'b0001, 0, 0, 4'b0000);
    add(7,  0, 0, 0, 4'b0001, 0, 0, 4'b0000);
    add(3,  0, 0, 0, 4'b0001, 0, 0, 4'b0001);
    // Clean press held 100 cycles: pulse at edges 7 and 8 only; pattern change while held.
    add(6,  0, 1, 0, 4'b0001, 0, 0, 4'b0001);
    add(2,  0, 1, 0, 4'b0001, 1, 0, 4'b0001);
    add(20, 0, 1, 0, 4'b0001, 0, 0, 4'b0001);
    add(72, 0, 1, 0, 4'b1000, 0, 0, 4'b0001);
    // Release: back to idle at edge 7, new pattern visible from edge 8.
    add(7,  0, 0, 0, 4'b1000, 0, 0, 4'b0001);
    add(5,  0, 0, 0, 4'b1000, 0, 0, 4'b1000);
    // 3-cycle level glitch is rejected; a stable change lands at edge 7.
    add(3,  0, 0, 1, 4'b1000, 0, 0, 4'b1000);
    add(20, 0, 0, 0, 4'b1000, 0, 0, 4'b1000);
    add(6,  0, 0, 1, 4'b1000, 0, 0, 4'b1000);
    add(6,  0, 0, 1, 4'b1000, 0, 1, 4'b1000);
    // Bouncing press (toggle every 2 cycles for 12 cycles), then steady: one pulse.
    for (int k = 0; k < 3; k++) begin
      add(2, 0, 1, 1, 4'b1000, 0, 1, 4'b1000);
      add(2, 0, 0, 1, 4'b1000, 0, 1, 4'b1000);
    end
    add(6,  0, 1, 1, 4'b1000, 0, 1, 4'b1000);
    add(2,  0, 1, 1, 4'b1000, 1, 1, 4'b1000);
    add(10, 0, 1, 1, 4'b1000, 0, 1, 4'b1000);
    // Button held through reset and after: no pulse; release 6, press: one pulse.
    add(12, 0, 0, 1, 4'b1000, 0, 1, 4'b1000);
    add(2,  1, 1, 1, 4'b1000, 0, 0, 4'b0000);
    add(30, 0, 1, 1, 4'b1000, 0, 0, 4'b0000);
    add(6,  0, 0, 1, 4'b1000, 0, 0, 4'b0000);
    add(1,  0, 1, 1, 4'b1000, 0, 0, 4'b0000);
    add(5,  0, 1, 1, 4'b1000, 0, 1, 4'b1000);
    add(2,  0, 1, 1, 4'b1000, 1, 1, 4'b1000);
    add(4,  0, 1, 1, 4'b1000, 0, 1, 4'b1000);
    // Reset on the first FIRE cycle ends the pulse at once.
    add(12, 0, 0, 1, 4'b1000, 0, 1, 4'b1000);
    add(6,  0, 1, 1, 4'b1000, 0, 1, 4'b1000);
    add(1,  0, 1, 1, 4'b1000, 1, 1, 4'b1000);
    add(1,  1, 1, 1, 4'b1000, 0, 0, 4'b0000);
    add(7,  0, 0, 1, 4'b1000, 0, 0, 4'b0000);
    add(8,  0, 0, 1, 4'b1000, 0, 1, 4'b1000);

    foreach (tbl[t]) begin
      for (int c = 0; c < tbl[t].n; c++) begin
        rst        = tbl[t].rst;
        btn_step   = tbl[t].btn;
        sw_level   = tbl[t].lvl;
        sw_pattern = tbl[t].pat;
        tick();
        n_tests++;
        if (step_pulse !== tbl[t].e_pulse || level_out !== tbl[t].e_lvl ||
            pattern_out !== tbl[t].e_pat) begin
          n_fail++;
          $display("FAIL table[%0d] cycle %0d: got pulse=%b lvl=%b pat=%b, want pulse=%b lvl=%b pat=%b",
                   t, c, step_pulse, level_out, pattern_out,
                   tbl[t].e_pulse, tbl[t].e_lvl, tbl[t].e_pat);
        end
      end
    end

    // Randomized segments: held values of random length, mixing bounce and clean presses.
    for (int s = 0; s < 600; s++) begin
      rst        = ($urandom_range(0, 59) == 0);
      btn_step   = 1'($urandom_range(0, 1));
      sw_level   = ($urandom_range(0, 3) == 0) ? ~sw_level : sw_level;
      sw_pattern = ($urandom_range(0, 3) == 0) ? 4'($urandom) : sw_pattern;
      seg        = rst ? 1 : $urandom_range(1, 12);
      for (int c = 0; c < seg; c++) begin
        tick();
        n_tests++;
        if (step_pulse !== (m_mode == 1) || level_out !== m_lvl || pattern_out !== m_pat) begin
          n_fail++;
          $display("FAIL random seg %0d cycle %0d: got pulse=%b lvl=%b pat=%b, want pulse=%b lvl=%b pat=%b",
                   s, c, step_pulse, level_out, pattern_out, (m_mode == 1), m_lvl, m_pat);
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
